// File: rtl/csr_access_ctrl_pkg.sv
// Shared types and helpers for the CSR access controller.
//   csr_op_e  : requested CSR operation (read, read-write, read-set, read-clear)
//   state_e   : access sequencer states
//   CSR_*     : well-known CSR addresses
//   csr_ro()  : true when an address falls in the read-only CSR space
package csr_access_ctrl_pkg;

    typedef enum logic [1:0] {
        CsrRd = 2'b00,
        CsrRw = 2'b01,
        CsrRs = 2'b10,
        CsrRc = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StResp  = 2'b11
    } state_e;

    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;

    // Top two address bits set marks the read-only CSR space.
    function automatic logic csr_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_access_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   req_i      : request per requester (bit0 core, bit1 debug)
//   advance_i  : grant is being consumed this cycle; moves the priority pointer
//   gnt_o      : one-hot (or zero) combinational grant
module csr_access_ctrl_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    // Pointer names the requester that wins when both are requesting.
    logic ptr_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance_i && (gnt_o != 2'b00)) begin
            // Hand priority to the requester that was not just served.
            ptr_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR read-modify-write sequencer shared by the core EX stage (0) and debug (1).
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid_i     : request valid per requester
//   req_ready_o     : request accept per requester, one-hot or zero, only in idle
//   req_op_i        : csr_op_e per requester, {debug, core}
//   req_addr_i      : CSR address per requester, {debug, core}
//   req_wdata_i     : write/mask operand per requester, {debug, core}
//   resp_valid_o    : response valid, held until resp_ready_i
//   resp_ready_i    : response consumed
//   resp_id_o       : requester index of the response
//   resp_rdata_o    : CSR value before any write
//   resp_illegal_o  : write to a read-only CSR was attempted (and dropped)
//   csr_addr_o      : CSR file address
//   csr_rd_data_i   : CSR file combinational read data
//   csr_wr_en_o     : CSR file write strobe, single-cycle pulse
//   csr_wr_data_o   : CSR file write data
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [3:0]          req_op_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*XLEN-1:0]   req_wdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic                resp_id_o,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic                resp_illegal_o,
    output logic [ADDR_W-1:0]   csr_addr_o,
    input  logic [XLEN-1:0]     csr_rd_data_i,
    output logic                csr_wr_en_o,
    output logic [XLEN-1:0]     csr_wr_data_o
);

    state_e          state_q;
    csr_op_e         op_q;
    logic [XLEN-1:0] wdata_q;

    logic [1:0]        gnt;
    logic              sel_idx;
    csr_op_e           sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic [XLEN-1:0]   new_val;
    logic              wr_needed;
    logic              illegal;

    csr_access_ctrl_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid_i),
        .advance_i (state_q == StIdle),
        .gnt_o     (gnt)
    );

    assign req_ready_o = (state_q == StIdle) ? gnt : 2'b00;

    // Operand mux for the granted requester.
    always_comb begin
        sel_idx   = gnt[1];
        sel_op    = csr_op_e'(sel_idx ? req_op_i[3:2] : req_op_i[1:0]);
        sel_addr  = sel_idx ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
        sel_wdata = sel_idx ? req_wdata_i[XLEN +: XLEN] : req_wdata_i[0 +: XLEN];
    end

    // Read-modify-write ALU, evaluated in the read cycle against the live read data.
    always_comb begin
        new_val = csr_rd_data_i;
        unique case (op_q)
            CsrRw:   new_val = wdata_q;
            CsrRs:   new_val = csr_rd_data_i | wdata_q;
            CsrRc:   new_val = csr_rd_data_i & ~wdata_q;
            default: new_val = csr_rd_data_i;
        endcase
        // Set/clear with a zero mask has no side effect, so it never counts as a write.
        wr_needed = (op_q != CsrRd) && !(((op_q == CsrRs) || (op_q == CsrRc)) && (wdata_q == '0));
        illegal   = wr_needed && csr_ro(csr_addr_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= CsrRd;
            wdata_q        <= '0;
            resp_valid_o   <= 1'b0;
            resp_id_o      <= 1'b0;
            resp_rdata_o   <= '0;
            resp_illegal_o <= 1'b0;
            csr_addr_o     <= '0;
            csr_wr_en_o    <= 1'b0;
            csr_wr_data_o  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i != 2'b00) begin
                        op_q       <= sel_op;
                        csr_addr_o <= sel_addr;
                        wdata_q    <= sel_wdata;
                        resp_id_o  <= sel_idx;
                        state_q    <= StRead;
                    end
                end
                StRead: begin
                    resp_rdata_o   <= csr_rd_data_i;
                    resp_illegal_o <= illegal;
                    csr_wr_en_o    <= wr_needed && !illegal;
                    csr_wr_data_o  <= new_val;
                    state_q        <= StWrite;
                end
                StWrite: begin
                    csr_wr_en_o  <= 1'b0;
                    resp_valid_o <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [23:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [11:0] csr_addr;
    logic [31:0] csr_rd_data;
    logic        csr_wr_en;
    logic [31:0] csr_wr_data;

    int total = 0;
    int bad   = 0;

    csr_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_id_o      (resp_id),
        .resp_rdata_o   (resp_rdata),
        .resp_illegal_o (resp_illegal),
        .csr_addr_o     (csr_addr),
        .csr_rd_data_i  (csr_rd_data),
        .csr_wr_en_o    (csr_wr_en),
        .csr_wr_data_o  (csr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- CSR file environment ----------------
    int unsigned cyc = 0;
    int unsigned wr_cnt = 0;
    logic [31:0] env_mem [0:4095];
    bit          env_wr  [0:4095];

    function automatic logic [31:0] init_val(input logic [11:0] a);
        if (a == 12'h340) return 32'h0000_1234;
        return ({20'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Read-only space behaves as free-running counters.
    function automatic logic [31:0] env_read(input logic [11:0] a);
        if (a[11:10] == 2'b11) return cyc + {20'd0, a};
        return env_wr[a] ? env_mem[a] : init_val(a);
    endfunction

    always_comb begin
        csr_rd_data = init_val(csr_addr);
        if (csr_addr[11:10] == 2'b11) csr_rd_data = cyc + {20'd0, csr_addr};
        else if (env_wr[csr_addr])    csr_rd_data = env_mem[csr_addr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && csr_wr_en) begin
            env_mem[csr_addr] <= csr_wr_data;
            env_wr[csr_addr]  <= 1'b1;
            wr_cnt            <= wr_cnt + 1;
        end
    end

    // ---------------- behavioural reference ----------------
    // One op in flight; it is one cycle into its life in the read cycle, two in the write
    // cycle, and responding from three onward until resp_ready.
    logic [31:0] sh_mem [0:4095];
    bit          sh_wr  [0:4095];
    bit          m_busy = 1'b0;
    bit          m_ptr  = 1'b0;
    int          m_age  = 0;
    logic [1:0]  m_op;
    logic [11:0] m_addr;
    logic [31:0] m_wd, m_old, m_new;
    logic        m_id, m_wr, m_ill, m_need;
    logic [1:0]  exp_ready;

    function automatic logic [31:0] sh_read(input logic [11:0] a);
        if (a[11:10] == 2'b11) return cyc + {20'd0, a};
        return sh_wr[a] ? sh_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            exp_ready = 2'b00;
            if (!m_busy) begin
                if (req_valid == 2'b11) exp_ready = m_ptr ? 2'b10 : 2'b01;
                else                    exp_ready = req_valid;
            end
            chk32("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
            chk1("csr_wr_en", csr_wr_en, m_busy && (m_age == 2) && m_wr);
            if (m_busy && (m_age == 2) && m_wr) chk32("csr_wr_data", csr_wr_data, m_new);
            if (m_busy && (m_age <= 2)) chk32("csr_addr", {20'd0, csr_addr}, {20'd0, m_addr});
            chk1("resp_valid", resp_valid, m_busy && (m_age >= 3));
            if (m_busy && (m_age >= 3)) begin
                chk1("resp_id", resp_id, m_id);
                chk32("resp_rdata", resp_rdata, m_old);
                chk1("resp_illegal", resp_illegal, m_ill);
            end

            if (!m_busy) begin
                if (exp_ready != 2'b00) begin
                    m_id   = exp_ready[1];
                    m_op   = m_id ? req_op[3:2] : req_op[1:0];
                    m_addr = m_id ? req_addr[23:12] : req_addr[11:0];
                    m_wd   = m_id ? req_wdata[63:32] : req_wdata[31:0];
                    m_ptr  = !m_id;
                    m_busy = 1'b1;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_old = sh_read(m_addr);
                case (m_op)
                    2'b01:   m_new = m_wd;
                    2'b10:   m_new = m_old | m_wd;
                    2'b11:   m_new = m_old & ~m_wd;
                    default: m_new = m_old;
                endcase
                m_need = (m_op == 2'b01) || ((m_op[1] == 1'b1) && (m_wd != 32'd0));
                m_ill  = m_need && (m_addr[11:10] == 2'b11);
                m_wr   = m_need && !m_ill;
                m_age  = 2;
            end else if (m_age == 2) begin
                if (m_wr) begin
                    sh_mem[m_addr] = m_new;
                    sh_wr[m_addr]  = 1'b1;
                end
                m_age = 3;
            end else if (resp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int id, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd);
        if (id == 0) begin
            req_op[1:0] = op; req_addr[11:0] = a; req_wdata[31:0] = wd;
        end else begin
            req_op[3:2] = op; req_addr[23:12] = a; req_wdata[63:32] = wd;
        end
    endtask

    // Issues one op and returns at the first cycle its response is visible.
    task automatic run_op(input int id, input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic ill,
                          output logic rid, output int unsigned lat, output int unsigned hc);
        bit got = 0;
        rd = '0; ill = 1'b0; rid = 1'b0; lat = 0; hc = 0;
        drv(id, op, a, wd);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                hc  = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        chk1("grant_timeout", got, 1'b1);
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                lat = cyc - hc;
                rd  = resp_rdata;
                ill = resp_illegal;
                rid = resp_id;
                break;
            end
        end
        chk1("resp_timeout", got, 1'b1);
    endtask

    function automatic logic [11:0] pick_addr(input int k);
        case (k)
            0:       return 12'h340;
            1:       return 12'h341;
            2:       return 12'h300;
            3:       return 12'h305;
            4:       return 12'hC00;
            5:       return 12'hC01;
            6:       return 12'hC02;
            default: return 12'hB00;
        endcase
    endfunction

    logic [31:0] rd;
    logic        ill, rid;
    int unsigned lat, hc, w0;
    logic [31:0] hold_rd;
    logic [1:0]  order [4];
    int          ngr;

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk32("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_id", resp_id, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'd0);
        chk1("rst_resp_illegal", resp_illegal, 1'b0);
        chk32("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        chk1("rst_csr_wr_en", csr_wr_en, 1'b0);
        chk32("rst_csr_wr_data", csr_wr_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: core RW to a scratch CSR
        w0 = wr_cnt;
        run_op(0, 2'b01, 12'h340, 32'hDEAD_BEEF, rd, ill, rid, lat, hc);
        chk32("t1_rdata", rd, 32'h0000_1234);
        chk1("t1_illegal", ill, 1'b0);
        chk1("t1_id", rid, 1'b0);
        chk32("t1_latency", lat, 32'd3);
        chk32("t1_wr_pulses", wr_cnt - w0, 32'd1);
        chk32("t1_csr_value", env_read(12'h340), 32'hDEAD_BEEF);
        tick();

        // T2: core RS with zero mask on CYCLE: plain read, value from the read cycle
        w0 = wr_cnt;
        run_op(0, 2'b10, 12'hC00, 32'd0, rd, ill, rid, lat, hc);
        chk32("t2_rdata", rd, hc + 32'd1 + 32'h0000_0C00);
        chk1("t2_illegal", ill, 1'b0);
        chk32("t2_wr_pulses", wr_cnt - w0, 32'd0);
        tick();

        // T3: debug RC with nonzero mask on a counter: illegal, dropped
        w0 = wr_cnt;
        run_op(1, 2'b11, 12'hC02, 32'h0000_000F, rd, ill, rid, lat, hc);
        chk1("t3_illegal", ill, 1'b1);
        chk1("t3_id", rid, 1'b1);
        chk32("t3_wr_pulses", wr_cnt - w0, 32'd0);
        tick();

        // T4: both requesters held valid; grants must alternate starting at core
        drv(0, 2'b00, 12'h300, 32'h1111_1111);
        drv(1, 2'b00, 12'h305, 32'h2222_2222);
        req_valid = 2'b11;
        ngr = 0;
        for (int i = 0; i < 40 && ngr < 4; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                order[ngr] = req_ready;
                ngr++;
            end
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        chk32("t4_grants", ngr, 32'd4);
        chk32("t4_order0", {30'd0, order[0]}, 32'd1);
        chk32("t4_order1", {30'd0, order[1]}, 32'd2);
        chk32("t4_order2", {30'd0, order[2]}, 32'd1);
        chk32("t4_order3", {30'd0, order[3]}, 32'd2);
        repeat (8) tick();

        // T5: response back-pressure with debug waiting
        resp_ready = 1'b0;
        run_op(0, 2'b01, 12'h300, 32'hA5A5_0001, rd, ill, rid, lat, hc);
        hold_rd = rd;
        drv(1, 2'b00, 12'h341, 32'd0);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t5_resp_held", resp_valid, 1'b1);
            chk32("t5_rdata_held", resp_rdata, hold_rd);
            chk32("t5_no_accept", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("t5_resp_done", resp_valid, 1'b0);
        chk32("t5_debug_ready", {30'd0, req_ready}, 32'd2);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (6) tick();

        // T6: reset while the write strobe is up
        drv(0, 2'b01, 12'h341, 32'hCAFE_F00D);
        req_valid = 2'b01;
        @(negedge clk);
        chk32("t6_accept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        chk1("t6_wr_pending", csr_wr_en, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t6_wr_en", csr_wr_en, 1'b0);
        chk1("t6_resp_valid", resp_valid, 1'b0);
        chk32("t6_csr_addr", {20'd0, csr_addr}, 32'd0);
        chk32("t6_csr_wr_data", csr_wr_data, 32'd0);
        chk32("t6_resp_rdata", resp_rdata, 32'd0);
        tick();
        rst = 1'b0;
        chk32("t6_no_write", env_read(12'h341), init_val(12'h341));
        drv(0, 2'b00, 12'h300, 32'd0);
        drv(1, 2'b00, 12'h305, 32'd0);
        req_valid = 2'b11;
        @(negedge clk);
        chk32("t6_ptr_reset", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        repeat (6) tick();

        // Randomized traffic against the reference model
        repeat (1500) begin
            tick();
            req_valid = 2'($urandom_range(0, 3));
            for (int id = 0; id < 2; id++) begin
                logic [1:0]  r_op;
                logic [11:0] r_a;
                logic [31:0] r_wd;
                r_op = 2'($urandom_range(0, 3));
                r_a  = pick_addr(int'($urandom_range(0, 7)));
                r_wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                drv(id, r_op, r_a, r_wd);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
